load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 30 +++
 rtl/lsu_byte_lane.sv | 41 ++++
 rtl/load_store_unit.sv | 153 +++++++++++++++
 tb/tb_load_store_unit.sv | 471 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size encodings,
// FSM state enum and the misalignment predicate.
package lsu_pkg;

  localparam logic [1:0] SIZE_WORD = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_BYTE = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    WAIT = 2'b10,
    RESP = 2'b11
  } lsu_state_e;

  // Half needs 2-byte alignment, word (00 or 11) needs 4-byte alignment.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] off);
    logic mis;
    mis = 1'b0;
    case (size)
      SIZE_BYTE: mis = 1'b0;
      SIZE_HALF: mis = off[0];
      SIZE_WORD: mis = (off != 2'b00);
      default:   mis = (off != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Byte-lane steering: byte enables and store-data replication toward memory,
// right-alignment of the raw read word toward the core. Purely combinational.
// Offset bits that do not apply to a size are ignored, which gives silent
// alignment of half/word accesses.
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata_raw,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_shift
);

  // Lane placement and right shift selected by access size
  always_comb begin
    be          = 4'b1111;
    wdata_lane  = wdata;
    rdata_shift = rdata_raw;
    case (size)
      SIZE_BYTE: begin
        be          = 4'b0001 << off;
        wdata_lane  = {4{wdata[7:0]}};
        rdata_shift = rdata_raw >> {off, 3'b000};
      end
      SIZE_HALF: begin
        be          = 4'b0011 << {off[1], 1'b0};
        wdata_lane  = {2{wdata[15:0]}};
        rdata_shift = rdata_raw >> {off[1], 4'b0000};
      end
      default: begin
        be          = 4'b1111;
        wdata_lane  = wdata;
        rdata_shift = rdata_raw;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one request at a time, issues a single memory
// request (req/gnt), waits for the response/ack (rvalid), then pulses
// rsp_valid_o with right-aligned, unextended read data.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (trap misaligned half/word
// accesses instead of silently aligning them).
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              we_i,
  input  logic [1:0]        size_i,
  input  logic              sign_extend_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [3:0]        mem_be_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [31:0]       mem_rdata_i,
  output logic              rsp_valid_o,
  output logic [31:0]       rdata_o,
  output logic [1:0]        trim_o,
  output logic              sign_extend_o,
  output logic              misalign_o,
  output logic              busy_o
);

  lsu_state_e        state_q, state_d;
  logic              accept;
  logic              trap;
  logic              we_q;
  logic [1:0]        size_q;
  logic              sign_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic [3:0]        lane_be;
  logic [31:0]       lane_wdata;
  logic [31:0]       lane_rdata;

  assign req_ready_o   = (state_q == IDLE);
  assign busy_o        = (state_q != IDLE);
  assign accept        = req_valid_i & req_ready_o;
  assign rdata_o       = rdata_q;
  assign trim_o        = size_q;
  assign sign_extend_o = sign_q;

`ifdef LSU_MISALIGN_TRAP_EN
  logic mis_q;

  assign trap       = is_misaligned(size_i, addr_i[1:0]);
  assign misalign_o = mis_q & (state_q == RESP);

  // Misalignment verdict captured with the request
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mis_q <= 1'b0;
    end else if (accept) begin
      mis_q <= trap;
    end
  end
`else
  assign trap       = 1'b0;
  assign misalign_o = 1'b0;
`endif

  lsu_byte_lane u_lane (
    .size        (size_q),
    .off         (addr_q[1:0]),
    .wdata       (wdata_q),
    .rdata_raw   (mem_rdata_i),
    .be          (lane_be),
    .wdata_lane  (lane_wdata),
    .rdata_shift (lane_rdata)
  );

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request attributes latched on acceptance; read data captured on response
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      we_q    <= 1'b0;
      size_q  <= '0;
      sign_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else if (accept) begin
      we_q    <= we_i;
      size_q  <= size_i;
      sign_q  <= sign_extend_i;
      addr_q  <= addr_i;
      wdata_q <= wdata_i;
      rdata_q <= '0;
    end else if ((state_q == WAIT) && mem_rvalid_i) begin
      rdata_q <= we_q ? '0 : lane_rdata;
    end
  end

  // Next-state and memory/response outputs
  always_comb begin
    state_d     = state_q;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    rsp_valid_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = trap ? RESP : REQ;
        end
      end
      REQ: begin
        mem_req_o   = 1'b1;
        mem_we_o    = we_q;
        mem_be_o    = lane_be;
        mem_addr_o  = {addr_q[ADDR_W-1:2], 2'b00};
        mem_wdata_o = lane_wdata;
        if (mem_gnt_i) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (mem_rvalid_i) begin
          state_d = RESP;
        end
      end
      RESP: begin
        rsp_valid_o = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: a scoreboard of expected
// transaction results, a memory-side driver with configurable grant and
// response delays, and per-scenario check tasks.
module tb_load_store_unit;

  logic        clk_i;
  logic        rst_ni;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        we_i;
  logic [1:0]  size_i;
  logic        sign_extend_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        rsp_valid_o;
  logic [31:0] rdata_o;
  logic [1:0]  trim_o;
  logic        sign_extend_o;
  logic        misalign_o;
  logic        busy_o;

  int errors;
  int checks;

  typedef struct packed {
    logic        trap;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [1:0]  trim;
    logic        sign;
  } exp_t;

  typedef struct packed {
    logic        ready;
    logic [7:0]  req_cyc;
    logic        extra_req;
    logic        unstable;
    logic        m_we;
    logic [3:0]  m_be;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [7:0]  rsp_cnt;
    logic [7:0]  lat;
    logic        rdy_rsp;
    logic [31:0] rdata;
    logic [1:0]  trim;
    logic        sign;
    logic        mis;
    logic [1:0]  trim_after;
    logic        sign_after;
  } obs_t;

  exp_t sb[$];

  load_store_unit #(.ADDR_W(32)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .we_i          (we_i),
    .size_i        (size_i),
    .sign_extend_i (sign_extend_i),
    .addr_i        (addr_i),
    .wdata_i       (wdata_i),
    .mem_req_o     (mem_req_o),
    .mem_we_o      (mem_we_o),
    .mem_be_o      (mem_be_o),
    .mem_addr_o    (mem_addr_o),
    .mem_wdata_o   (mem_wdata_o),
    .mem_gnt_i     (mem_gnt_i),
    .mem_rvalid_i  (mem_rvalid_i),
    .mem_rdata_i   (mem_rdata_i),
    .rsp_valid_o   (rsp_valid_o),
    .rdata_o       (rdata_o),
    .trim_o        (trim_o),
    .sign_extend_o (sign_extend_o),
    .misalign_o    (misalign_o),
    .busy_o        (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference behaviour of one transaction
  function automatic exp_t model(input logic we, input logic [1:0] size,
                                 input logic sign, input logic [31:0] addr,
                                 input logic [31:0] wd, input logic [31:0] rw);
    exp_t e;
    logic [1:0] off;
    off = addr[1:0];
    e = '0;
    e.we   = we;
    e.addr = {addr[31:2], 2'b00};
    e.trim = size;
    e.sign = sign;
    case (size)
      2'b10: begin
        e.be    = 4'b0001 << off;
        e.wdata = {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
        e.rdata = rw >> (8 * off);
      end
      2'b01: begin
        e.be    = off[1] ? 4'b1100 : 4'b0011;
        e.wdata = {wd[15:0], wd[15:0]};
        e.rdata = off[1] ? {16'h0000, rw[31:16]} : rw;
      end
      default: begin
        e.be    = 4'b1111;
        e.wdata = wd;
        e.rdata = rw;
      end
    endcase
    if (we) e.rdata = '0;
`ifdef LSU_MISALIGN_TRAP_EN
    e.trap = ((size == 2'b01) && off[0]) ||
             (((size == 2'b00) || (size == 2'b11)) && (off != 2'b00));
    if (e.trap) e.rdata = '0;
`endif
    return e;
  endfunction

  // Drive one request and act as memory; collects observations (no checks)
  task automatic run_txn(input logic we, input logic [1:0] size,
                         input logic sign, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] rw,
                         input int unsigned gdly, input int unsigned rdly,
                         input logic stray, output obs_t o);
    int unsigned waitc;
    int unsigned rsp_at;
    logic granted;
    o = '0;
    waitc = 0;
    rsp_at = 0;
    granted = 1'b0;
    o.ready = req_ready_o;
    req_valid_i = 1'b1;
    we_i = we;
    size_i = size;
    sign_extend_i = sign;
    addr_i = addr;
    wdata_i = wd;
    mem_rdata_i = rw;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    addr_i = ~addr;
    wdata_i = ~wd;
    size_i = ~size;
    sign_extend_i = ~sign;
    for (int unsigned c = 1; c <= 60; c++) begin
      mem_gnt_i = 1'b0;
      mem_rvalid_i = 1'b0;
      if (rsp_at != 0 && c >= rsp_at + 1) begin
        o.trim_after = trim_o;
        o.sign_after = sign_extend_o;
        break;
      end
      if (rsp_valid_o) begin
        o.rsp_cnt = o.rsp_cnt + 8'd1;
        if (o.rsp_cnt == 8'd1) begin
          rsp_at  = c;
          o.lat   = 8'(c);
          o.rdata = rdata_o;
          o.trim  = trim_o;
          o.sign  = sign_extend_o;
          o.mis   = misalign_o;
          o.rdy_rsp = req_ready_o;
        end
      end
      if (mem_req_o) begin
        o.req_cyc = o.req_cyc + 8'd1;
        if (granted) o.extra_req = 1'b1;
        if (o.req_cyc == 8'd1) begin
          o.m_we = mem_we_o;
          o.m_be = mem_be_o;
          o.m_addr = mem_addr_o;
          o.m_wdata = mem_wdata_o;
        end else if ({mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o} !==
                     {o.m_we, o.m_be, o.m_addr, o.m_wdata}) begin
          o.unstable = 1'b1;
        end
        if (32'(o.req_cyc) > gdly) begin
          mem_gnt_i = 1'b1;
          granted = 1'b1;
        end else if (stray) begin
          mem_rvalid_i = 1'b1;
        end
      end else if (granted && busy_o && !rsp_valid_o) begin
        waitc++;
        if (waitc > rdly) mem_rvalid_i = 1'b1;
      end
      @(posedge clk_i); #1;
    end
    mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    req_valid_i = 1'b0; we_i = 1'b0; size_i = 2'b00; sign_extend_i = 1'b0;
    addr_i = '0; wdata_i = '0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    mem_rdata_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    checks++;
    if ({mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o, rsp_valid_o,
         rdata_o, trim_o, sign_extend_o, misalign_o, busy_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got req=%b we=%b be=%b addr=%h wd=%h rsp=%b rd=%h trim=%b sx=%b mis=%b busy=%b, expected all zero",
               mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o, rsp_valid_o,
               rdata_o, trim_o, sign_extend_o, misalign_o, busy_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    checks++;
    if (req_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b expected 1", req_ready_o);
    end
  endtask

  task automatic test_load_byte();
    exp_t e;
    obs_t o;
    sb.push_back(model(1'b0, 2'b10, 1'b1, 32'h103, 32'h0, 32'hAABBCCDD));
    run_txn(1'b0, 2'b10, 1'b1, 32'h103, 32'h0, 32'hAABBCCDD, 0, 0, 1'b0, o);
    e = sb.pop_front();
    checks++;
    if ({o.m_we, o.m_be, o.m_addr} !== {e.we, e.be, e.addr}) begin
      errors++;
      $display("FAIL lb_mem: got we=%b be=%b addr=%h expected we=%b be=%b addr=%h",
               o.m_we, o.m_be, o.m_addr, e.we, e.be, e.addr);
    end
    checks++;
    if (o.rdata !== e.rdata) begin
      errors++;
      $display("FAIL lb_rdata: got %h expected %h", o.rdata, e.rdata);
    end
    checks++;
    if ({o.trim, o.sign, o.trim_after, o.sign_after} !== {e.trim, e.sign, e.trim, e.sign}) begin
      errors++;
      $display("FAIL lb_trim_sign: got trim=%b sx=%b after=%b/%b expected %b/%b",
               o.trim, o.sign, o.trim_after, o.sign_after, e.trim, e.sign);
    end
    checks++;
    if (o.lat !== 8'd3 || o.rsp_cnt !== 8'd1) begin
      errors++;
      $display("FAIL lb_latency: got lat=%0d pulses=%0d expected lat=3 pulses=1", o.lat, o.rsp_cnt);
    end
    checks++;
    if (o.ready !== 1'b1 || o.rdy_rsp !== 1'b0) begin
      errors++;
      $display("FAIL lb_ready: got idle=%b resp=%b expected idle=1 resp=0", o.ready, o.rdy_rsp);
    end
  endtask

  task automatic test_store_half();
    exp_t e;
    obs_t o;
    sb.push_back(model(1'b1, 2'b01, 1'b0, 32'h202, 32'h00001234, 32'hDEADBEEF));
    run_txn(1'b1, 2'b01, 1'b0, 32'h202, 32'h00001234, 32'hDEADBEEF, 0, 1, 1'b0, o);
    e = sb.pop_front();
    checks++;
    if ({o.m_we, o.m_be, o.m_addr, o.m_wdata} !== {e.we, e.be, e.addr, e.wdata}) begin
      errors++;
      $display("FAIL sh_mem: got we=%b be=%b addr=%h wd=%h expected we=%b be=%b addr=%h wd=%h",
               o.m_we, o.m_be, o.m_addr, o.m_wdata, e.we, e.be, e.addr, e.wdata);
    end
    checks++;
    if (o.rdata !== e.rdata) begin
      errors++;
      $display("FAIL sh_rdata: got %h expected %h", o.rdata, e.rdata);
    end
    checks++;
    if (o.lat !== 8'd4 || o.rsp_cnt !== 8'd1) begin
      errors++;
      $display("FAIL sh_ack: got lat=%0d pulses=%0d expected lat=4 pulses=1", o.lat, o.rsp_cnt);
    end
  endtask

  task automatic test_gnt_delay();
    exp_t e;
    obs_t o;
    sb.push_back(model(1'b0, 2'b00, 1'b0, 32'h440, 32'h0, 32'h01234567));
    run_txn(1'b0, 2'b00, 1'b0, 32'h440, 32'h0, 32'h01234567, 3, 0, 1'b1, o);
    e = sb.pop_front();
    checks++;
    if (o.req_cyc !== 8'd4 || o.unstable !== 1'b0 || o.extra_req !== 1'b0) begin
      errors++;
      $display("FAIL gd_req: got cycles=%0d unstable=%b extra=%b expected 4/0/0",
               o.req_cyc, o.unstable, o.extra_req);
    end
    checks++;
    if ({o.m_be, o.m_addr} !== {e.be, e.addr}) begin
      errors++;
      $display("FAIL gd_mem: got be=%b addr=%h expected be=%b addr=%h", o.m_be, o.m_addr, e.be, e.addr);
    end
    checks++;
    if (o.rsp_cnt !== 8'd1 || o.lat !== 8'd6 || o.rdata !== e.rdata) begin
      errors++;
      $display("FAIL gd_rsp: got pulses=%0d lat=%0d rd=%h expected 1/6/%h",
               o.rsp_cnt, o.lat, o.rdata, e.rdata);
    end
  endtask

  task automatic test_word_misaligned();
    exp_t e;
    obs_t o;
    sb.push_back(model(1'b0, 2'b00, 1'b0, 32'h101, 32'h0, 32'h11223344));
    run_txn(1'b0, 2'b00, 1'b0, 32'h101, 32'h0, 32'h11223344, 0, 0, 1'b0, o);
    e = sb.pop_front();
    checks++;
    if (o.req_cyc !== (e.trap ? 8'd0 : 8'd1)) begin
      errors++;
      $display("FAIL wm_req: got %0d request cycles expected %0d", o.req_cyc, e.trap ? 0 : 1);
    end
    checks++;
    if (o.mis !== e.trap || o.rsp_cnt !== 8'd1) begin
      errors++;
      $display("FAIL wm_flag: got mis=%b pulses=%0d expected mis=%b pulses=1", o.mis, o.rsp_cnt, e.trap);
    end
    checks++;
    if (o.rdata !== e.rdata || o.lat !== (e.trap ? 8'd1 : 8'd3)) begin
      errors++;
      $display("FAIL wm_rsp: got rd=%h lat=%0d expected rd=%h lat=%0d",
               o.rdata, o.lat, e.rdata, e.trap ? 1 : 3);
    end
    if (!e.trap) begin
      checks++;
      if ({o.m_be, o.m_addr} !== {e.be, e.addr}) begin
        errors++;
        $display("FAIL wm_mem: got be=%b addr=%h expected be=%b addr=%h", o.m_be, o.m_addr, e.be, e.addr);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    obs_t o;
    logic we;
    logic [1:0] size;
    logic sign;
    logic [31:0] addr, wd, rw;
    int unsigned gd, rd;
    for (int n = 0; n < 16; n++) begin
      we = 1'($urandom_range(0, 1));
      size = 2'($urandom_range(0, 3));
      sign = 1'($urandom_range(0, 1));
      addr = $urandom;
      wd = $urandom;
      rw = $urandom;
      gd = $urandom_range(0, 2);
      rd = $urandom_range(0, 2);
      sb.push_back(model(we, size, sign, addr, wd, rw));
      run_txn(we, size, sign, addr, wd, rw, gd, rd, 1'($urandom_range(0, 1)), o);
      e = sb.pop_front();
      checks++;
      if (o.rsp_cnt !== 8'd1 || o.ready !== 1'b1 ||
          o.lat !== (e.trap ? 8'd1 : 8'(gd + rd + 3))) begin
        errors++;
        $display("FAIL b2b_flow[%0d]: got pulses=%0d ready=%b lat=%0d expected 1/1/%0d",
                 n, o.rsp_cnt, o.ready, o.lat, e.trap ? 1 : gd + rd + 3);
      end
      checks++;
      if (e.trap ? (o.req_cyc !== 8'd0)
                 : ({o.req_cyc, o.m_we, o.m_be, o.m_addr, o.m_wdata} !==
                    {8'(gd + 1), e.we, e.be, e.addr, e.wdata})) begin
        errors++;
        $display("FAIL b2b_mem[%0d]: got cyc=%0d we=%b be=%b addr=%h wd=%h expected trap=%b cyc=%0d we=%b be=%b addr=%h wd=%h",
                 n, o.req_cyc, o.m_we, o.m_be, o.m_addr, o.m_wdata,
                 e.trap, gd + 1, e.we, e.be, e.addr, e.wdata);
      end
      checks++;
      if ({o.rdata, o.trim, o.sign, o.mis} !== {e.rdata, e.trim, e.sign, e.trap}) begin
        errors++;
        $display("FAIL b2b_rsp[%0d]: got rd=%h trim=%b sx=%b mis=%b expected rd=%h trim=%b sx=%b mis=%b",
                 n, o.rdata, o.trim, o.sign, o.mis, e.rdata, e.trim, e.sign, e.trap);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic rsp_seen;
    exp_t e;
    obs_t o;
    req_valid_i = 1'b1; we_i = 1'b0; size_i = 2'b10; sign_extend_i = 1'b1;
    addr_i = 32'h33; wdata_i = 32'h5A5A5A5A; mem_rdata_i = 32'hCAFEF00D;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    checks++;
    if (mem_req_o !== 1'b1) begin
      errors++;
      $display("FAIL rm_req: got mem_req=%b expected 1", mem_req_o);
    end
    mem_gnt_i = 1'b1;
    @(posedge clk_i); #1;
    mem_gnt_i = 1'b0;
    checks++;
    if ({busy_o, mem_req_o, rsp_valid_o} !== 3'b100) begin
      errors++;
      $display("FAIL rm_wait: got busy/req/rsp=%b expected 100", {busy_o, mem_req_o, rsp_valid_o});
    end
    rst_ni = 1'b0;
    #1;
    checks++;
    if ({mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o, rsp_valid_o,
         rdata_o, trim_o, sign_extend_o, misalign_o, busy_o} !== '0) begin
      errors++;
      $display("FAIL rm_reset_outputs: got req=%b be=%b addr=%h rd=%h trim=%b sx=%b busy=%b expected all zero",
               mem_req_o, mem_be_o, mem_addr_o, rdata_o, trim_o, sign_extend_o, busy_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    mem_rvalid_i = 1'b1;
    @(posedge clk_i); #1;
    mem_rvalid_i = 1'b0;
    rsp_seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (rsp_valid_o || busy_o) rsp_seen = 1'b1;
      @(posedge clk_i); #1;
    end
    checks++;
    if (rsp_seen !== 1'b0 || req_ready_o !== 1'b1 || rdata_o !== 32'h0 || trim_o !== 2'b00) begin
      errors++;
      $display("FAIL rm_stray: got activity=%b ready=%b rd=%h trim=%b expected 0/1/0/00",
               rsp_seen, req_ready_o, rdata_o, trim_o);
    end
    sb.push_back(model(1'b0, 2'b01, 1'b1, 32'h506, 32'h0, 32'h8765ABCD));
    run_txn(1'b0, 2'b01, 1'b1, 32'h506, 32'h0, 32'h8765ABCD, 0, 0, 1'b0, o);
    e = sb.pop_front();
    checks++;
    if ({o.rsp_cnt, o.m_be, o.rdata} !== {8'd1, e.be, e.rdata}) begin
      errors++;
      $display("FAIL rm_recover: got pulses=%0d be=%b rd=%h expected 1 be=%b rd=%h",
               o.rsp_cnt, o.m_be, o.rdata, e.be, e.rdata);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_load_byte();
    test_store_half();
    test_gnt_delay();
    test_word_misaligned();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
